// File: rtl/alu_pkg.sv
// Shared operation codes and shifter mode constants for the execute-stage ALU.
// Decoders elsewhere in the processor import this package for the opcode set.
package alu_pkg;

    // Operation select presented on the ALU operation port.
    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        XOR = 4'b0010,
        OR  = 4'b0011,
        AND = 4'b0100,
        SLL = 4'b0101,
        SRL = 4'b0110,
        SRA = 4'b0111,
        SLT = 4'b1000
    } alu_op_t;

    // Raw opcode constants for decoders that work on plain vectors.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    // Shifter mode select.
    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_NONE = 2'b11
    } sh_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic shifter: logical left, logical right and
// arithmetic right by an S-bit amount. Upper bits of the raw operand are
// dropped by the caller, so only the low S bits ever reach this block.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [S-1:0] shamt,
    input  sh_mode_t     mode,
    output logic [N-1:0] result
);

    logic          w_right;
    logic          w_fill;
    logic [N-1:0]  w_rev_in;
    logic [N-1:0]  w_stage [0:S];
    logic [N-1:0]  w_rev_out;

    // Decode direction and fill bit; left shifts are done as right shifts of the
    // bit-reversed operand so a single right-shifting network serves all modes.
    always_comb begin
        w_right = 1'b0;
        w_fill  = 1'b0;
        case (mode)
            SH_SLL: begin
                w_right = 1'b0;
                w_fill  = 1'b0;
            end
            SH_SRL: begin
                w_right = 1'b1;
                w_fill  = 1'b0;
            end
            SH_SRA: begin
                w_right = 1'b1;
                w_fill  = a[N-1];
            end
            default: begin
                w_right = 1'b1;
                w_fill  = 1'b0;
            end
        endcase
    end

    // Bit-reverse the operand for left shifts.
    always_comb begin
        w_rev_in = '0;
        for (int i = 0; i < N; i++) begin
            if (w_right) begin
                w_rev_in[i] = a[i];
            end else begin
                w_rev_in[i] = a[N-1-i];
            end
        end
    end

    assign w_stage[0] = w_rev_in;

    // One stage per shift-amount bit; stage k moves by 2**k when shamt[k] is set.
    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int STEP = 1 << k;
        // Right-shift stage k, inserting the fill bit at the top.
        always_comb begin
            w_stage[k+1] = w_stage[k];
            if (shamt[k]) begin
                for (int i = 0; i < N; i++) begin
                    if (i + STEP < N) begin
                        w_stage[k+1][i] = w_stage[k][i+STEP];
                    end else begin
                        w_stage[k+1][i] = w_fill;
                    end
                end
            end else begin
                w_stage[k+1] = w_stage[k];
            end
        end
    end

    // Undo the bit reversal for left shifts; the unused mode yields zero.
    always_comb begin
        w_rev_out = '0;
        for (int i = 0; i < N; i++) begin
            if (w_right) begin
                w_rev_out[i] = w_stage[S][i];
            end else begin
                w_rev_out[i] = w_stage[S][N-1-i];
            end
        end
        if (mode == SH_NONE) begin
            result = '0;
        end else begin
            result = w_rev_out;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Registered N-bit integer ALU for the execute stage. One shared adder serves
// ADD and SUB, an unsigned comparator serves SLT, and a single result register
// gives exactly one cycle of latency with synchronous active-high reset.
module alu_unit
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   operation,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] out
);

    localparam int S = $clog2(N);

    logic          w_sub;
    logic [N-1:0]  w_b_opnd;
    logic [N-1:0]  w_cin;
    logic [N-1:0]  w_sum;
    logic          w_lt;
    sh_mode_t      w_sh_mode;
    logic [N-1:0]  w_shift;
    logic [N-1:0]  w_result;
    logic [N-1:0]  r_out;

    // Adder operand select: SUB uses a + ~b + 1, everything else a + b.
    always_comb begin
        w_sub = (operation == OP_SUB);
        if (w_sub) begin
            w_b_opnd = ~b;
            w_cin    = {{(N-1){1'b0}}, 1'b1};
        end else begin
            w_b_opnd = b;
            w_cin    = '0;
        end
    end

    assign w_sum = a + w_b_opnd + w_cin;
    assign w_lt  = (a < b);

    // Map shift opcodes onto shifter modes; non-shift ops park it in SH_NONE.
    always_comb begin
        w_sh_mode = SH_NONE;
        case (operation)
            OP_SLL:  w_sh_mode = SH_SLL;
            OP_SRL:  w_sh_mode = SH_SRL;
            OP_SRA:  w_sh_mode = SH_SRA;
            default: w_sh_mode = SH_NONE;
        endcase
    end

    alu_shifter #(
        .N (N),
        .S (S)
    ) u_shifter (
        .a      (a),
        .shamt  (b[S-1:0]),
        .mode   (w_sh_mode),
        .result (w_shift)
    );

    // Result mux; unassigned and reserved opcodes produce zero.
    always_comb begin
        w_result = '0;
        unique case (operation)
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_sum;
            OP_XOR:  w_result = a ^ b;
            OP_OR:   w_result = a | b;
            OP_AND:  w_result = a & b;
            OP_SLL:  w_result = w_shift;
            OP_SRL:  w_result = w_shift;
            OP_SRA:  w_result = w_shift;
            OP_SLT:  w_result = {{(N-1){1'b0}}, w_lt};
            default: w_result = '0;
        endcase
    end

    // Output register: reset discards the operation sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_result;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_alu_unit.sv
// Directed and randomized bench for alu_unit (N = 32) with a behavioural
// reference model written as plain integer arithmetic.
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  operation;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;

    int n_checks;
    int n_fail;
    logic [31:0] prev_exp;

    alu_unit #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic on wide integers, reduced modulo 2**32.
    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] av,
                                          input logic [31:0] bv);
        longint unsigned ua, ub, two32;
        longint          sa;
        int              amt;
        ua    = longint'(av);
        ub    = longint'(bv);
        two32 = 64'd4294967296;
        amt   = int'(bv % 32'd32);
        sa    = av[31] ? (longint'(av) - longint'(two32)) : longint'(av);
        case (op)
            4'd0:    return 32'((ua + ub) % two32);
            4'd1:    return 32'((ua + two32 - ub) % two32);
            4'd2:    return av ^ bv;
            4'd3:    return av | bv;
            4'd4:    return av & bv;
            4'd5:    return 32'((ua * (64'd1 << amt)) % two32);
            4'd6:    return 32'(ua / (64'd1 << amt));
            4'd7:    return 32'(sa >>> amt);
            4'd8:    return (ua < ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present inputs on the falling edge, confirm out holds the old value,
    // then confirm the new result right after the next rising edge.
    task automatic step(input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp,
                        input string tag);
        @(negedge clk);
        operation = op;
        a = av;
        b = bv;
        #1;
        check({tag, "_hold"}, out, prev_exp);
        @(posedge clk);
        #1;
        check(tag, out, exp);
        prev_exp = exp;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        operation = 4'b0000;
        a         = 32'd5;
        b         = 32'd6;

        // Reset held for two edges with ADD 5+6 presented.
        @(posedge clk); #1;
        check("reset_edge1", out, 32'h0000_0000);
        @(posedge clk); #1;
        check("reset_edge2", out, 32'h0000_0000);
        prev_exp = 32'h0000_0000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", out, 32'h0000_000B);
        prev_exp = 32'h0000_000B;

        step(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_wrap");
        step(4'b0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, "add_small");
        step(4'b0001, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, "sub_small");
        step(4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");
        step(4'b0010, 32'h0000_000F, 32'h0000_00AA, 32'h0000_00A5, "xor");
        step(4'b0100, 32'hFF00_FF00, 32'h00FF_00FF, 32'h0000_0000, "and");
        step(4'b0011, 32'hFF00_FF00, 32'h00FF_00FF, 32'hFFFF_FFFF, "or");
        step(4'b0111, 32'h8000_0000, 32'h0000_0001, 32'hC000_0000, "sra_1");
        step(4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, "srl_1");
        step(4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll_31");
        step(4'b0111, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, "sra_upper_ignored");
        step(4'b0101, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "sll_0");
        step(4'b0111, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321, "sra_amt_wrap_0");
        step(4'b1000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "slt_lt");
        step(4'b1000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, "slt_gt");
        step(4'b1000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, "slt_eq");
        step(4'b1001, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, "invalid_9");
        step(4'b1111, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, "invalid_f");

        // Mid-stream reset discards the operation sampled at that edge.
        step(4'b0000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, "pre_reset");
        @(negedge clk);
        rst = 1'b1;
        operation = 4'b0011;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        @(posedge clk); #1;
        check("mid_reset", out, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_reset", out, 32'hFFFF_FFFF);
        prev_exp = 32'hFFFF_FFFF;

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ra = rb;
            end
            step(rop, ra, rb, model(rop, ra, rb), $sformatf("rand_op%0d", rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
